// File: rtl/sid_cycle_sequencer.sv
// SID cycle phase sequencer: fractional divider -> 4-strobe phase sequence, bus writes serialized into IDLE gaps; optional SID_CYCLE_COUNT_EN adds cycle_cnt.
// Latency: phase[PHI2_PHI1] one clk after the divider tick; reg_we/wr_ack one clk after a committing IDLE clk.
// Backpressure: wr_req is held until wr_ack; commits wait for an IDLE clk without tick, with one clk turnaround after each ack.
package sid;
    localparam int PHI2_PHI1 = 0;
    localparam int PHI1      = 1;
    localparam int PHI1_PHI2 = 2;
    localparam int PHI2      = 3;
    typedef logic [3:0] phase_t;
endpackage

module sid_cycle_sequencer #(
    parameter logic [23:0] CLK_INC = 24'd985248,
    parameter logic [23:0] CLK_MOD = 24'd12000000
) (
    input  logic        clk,
    input  logic        res,
    output sid::phase_t phase,
    input  logic        wr_req,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [7:0]  reg_data,
    output logic        overrun
`ifdef SID_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P21,
        ST_P1,
        ST_P12,
        ST_P2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [23:0] acc_q;
    logic [24:0] acc_sum;
    logic [23:0] acc_wrap;
    logic        tick;
    logic        commit;
    logic        overrun_set;
    sid::phase_t phase_d;

    // 25-bit sum so the compare never loses the carry out of the accumulator
    assign acc_sum  = {1'b0, acc_q} + {1'b0, CLK_INC};
    assign tick     = (acc_sum >= {1'b0, CLK_MOD});
    assign acc_wrap = acc_sum[23:0] - CLK_MOD;

    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        overrun_set = 1'b0;
        phase_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_P21;
                end else if (wr_req && !wr_ack) begin
                    // wr_ack high means this wr_req is the one just committed
                    commit = 1'b1;
                end
            end
            ST_P21:  state_d = ST_P1;
            ST_P1:   state_d = ST_P12;
            ST_P12:  state_d = ST_P2;
            ST_P2:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (tick && (state_q != ST_IDLE)) begin
            overrun_set = 1'b1;
        end

        case (state_d)
            ST_P21:  phase_d[sid::PHI2_PHI1] = 1'b1;
            ST_P1:   phase_d[sid::PHI1]      = 1'b1;
            ST_P12:  phase_d[sid::PHI1_PHI2] = 1'b1;
            ST_P2:   phase_d[sid::PHI2]      = 1'b1;
            default: phase_d                 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            acc_q    <= '0;
            state_q  <= ST_IDLE;
            phase    <= '0;
            wr_ack   <= 1'b0;
            reg_we   <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
            overrun  <= 1'b0;
        end else begin
            acc_q   <= tick ? acc_wrap : acc_sum[23:0];
            state_q <= state_d;
            phase   <= phase_d;
            wr_ack  <= commit;
            reg_we  <= commit;
            if (commit) begin
                reg_addr <= wr_addr;
                reg_data <= wr_data;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SID_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (res) begin
            cycle_cnt <= '0;
        end else if (phase_d[sid::PHI2_PHI1]) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sid_cycle_sequencer.sv
// Bench for sid_cycle_sequencer: cycle-indexed behavioural model for the main instance plus
// directed checks on an overrun instance (INC=1, MOD=3) and a real-rate instance.
module tb_sid_cycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_a = 1'b1;
    logic       res_b = 1'b1;
    logic       res_c = 1'b1;
    logic       wr_req = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic [3:0] phase_a, phase_b, phase_c;
    logic       wr_ack_a, wr_ack_b, wr_ack_c;
    logic       reg_we_a, reg_we_b, reg_we_c;
    logic [4:0] reg_addr_a, reg_addr_b, reg_addr_c;
    logic [7:0] reg_data_a, reg_data_b, reg_data_c;
    logic       ovr_a, ovr_b, ovr_c;
`ifdef SID_CYCLE_COUNT_EN
    logic [31:0] cnt_a, cnt_b, cnt_c;
`endif

    sid_cycle_sequencer #(.CLK_INC(24'd1), .CLK_MOD(24'd12)) dut_a (
`ifdef SID_CYCLE_COUNT_EN
        .cycle_cnt(cnt_a),
`endif
        .clk(clk), .res(res_a), .phase(phase_a),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack_a), .reg_we(reg_we_a), .reg_addr(reg_addr_a),
        .reg_data(reg_data_a), .overrun(ovr_a)
    );

    sid_cycle_sequencer #(.CLK_INC(24'd1), .CLK_MOD(24'd3)) dut_b (
`ifdef SID_CYCLE_COUNT_EN
        .cycle_cnt(cnt_b),
`endif
        .clk(clk), .res(res_b), .phase(phase_b),
        .wr_req(1'b0), .wr_addr(5'd0), .wr_data(8'd0),
        .wr_ack(wr_ack_b), .reg_we(reg_we_b), .reg_addr(reg_addr_b),
        .reg_data(reg_data_b), .overrun(ovr_b)
    );

    sid_cycle_sequencer #(.CLK_INC(24'd985248), .CLK_MOD(24'd12000000)) dut_c (
`ifdef SID_CYCLE_COUNT_EN
        .cycle_cnt(cnt_c),
`endif
        .clk(clk), .res(res_c), .phase(phase_c),
        .wr_req(1'b0), .wr_addr(5'd0), .wr_data(8'd0),
        .wr_ack(wr_ack_c), .reg_we(reg_we_c), .reg_addr(reg_addr_c),
        .reg_data(reg_data_c), .overrun(ovr_c)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        tot_cnt++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Model of instance A: the SID tick in cycle k (k counted from reset release) is
    // floor((k+1)*INC/MOD) > floor(k*INC/MOD); an accepted tick at cycle s produces the
    // one-hot strobe 1<<(c-s-1) in cycles s+1..s+4.
    localparam longint INC_A = 1;
    localparam longint MOD_A = 12;
    longint     m_cyc = 0;
    longint     m_start = -100;
    longint     m_d;
    bit         m_tick, m_busy, m_commit;
    bit         cmp_en = 1'b0;
    logic [3:0] e_phase = '0;
    logic       e_we = 1'b0, e_ack = 1'b0, e_ovr = 1'b0;
    logic [4:0] e_addr = '0;
    logic [7:0] e_data = '0;

    always @(posedge clk) begin
        if (res_a) begin
            m_cyc = 0; m_start = -100; e_phase = '0; e_we = 1'b0; e_ack = 1'b0;
            e_ovr = 1'b0; e_addr = '0; e_data = '0; cmp_en = 1'b1;
        end else begin
            m_tick = (((m_cyc + 1) * INC_A) / MOD_A) != ((m_cyc * INC_A) / MOD_A);
            m_busy = (m_cyc - m_start >= 1) && (m_cyc - m_start <= 4);
            if (m_tick && m_busy) e_ovr = 1'b1;
            if (m_tick && !m_busy) m_start = m_cyc;
            m_commit = !m_busy && !m_tick && wr_req && !e_ack;
            e_we = m_commit;
            e_ack = m_commit;
            if (m_commit) begin
                e_addr = wr_addr;
                e_data = wr_data;
            end
            m_cyc++;
            m_d = m_cyc - m_start;
            e_phase = (m_d >= 1 && m_d <= 4) ? (4'b0001 << (m_d - 1)) : 4'b0000;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("phase", {28'd0, phase_a}, {28'd0, e_phase});
            chk("reg_we", {31'd0, reg_we_a}, {31'd0, e_we});
            chk("wr_ack", {31'd0, wr_ack_a}, {31'd0, e_ack});
            chk("reg_addr", {27'd0, reg_addr_a}, {27'd0, e_addr});
            chk("reg_data", {24'd0, reg_data_a}, {24'd0, e_data});
            chk("overrun", {31'd0, ovr_a}, {31'd0, e_ovr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input longint n);
        int g;
        g = 0;
        while (m_cyc != n && g < 2000) begin
            step();
            g++;
        end
        if (m_cyc != n) fail_now("goto_cycle");
    endtask

    task automatic do_write(input longint start, input logic [4:0] a, input logic [7:0] d,
                            output longint ackc);
        goto(start);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        ackc    = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wr_ack_a === 1'b1) begin
                ackc = m_cyc;
                break;
            end
        end
        if (ackc < 0) begin
            fail_now("wr_ack_timeout");
        end else begin
            chk("ack_we", {31'd0, reg_we_a}, 32'd1);
            chk("ack_addr", {27'd0, reg_addr_a}, {27'd0, a});
            chk("ack_data", {24'd0, reg_data_a}, {24'd0, d});
        end
        step();
        wr_req = 1'b0;
    endtask

    initial begin
        longint ackc;
        int     strobes;

        repeat (2) step();
        chk("rst_phase", {28'd0, phase_a}, 32'd0);
        chk("rst_we", {31'd0, reg_we_a}, 32'd0);
        chk("rst_ack", {31'd0, wr_ack_a}, 32'd0);
        chk("rst_addr", {27'd0, reg_addr_a}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_a}, 32'd0);
        res_a = 1'b0;

        // First strobe 12 clks after release, then P21,P1,P12,P2 every 12 clks
        goto(11); chk("p_c11", {28'd0, phase_a}, 32'd0);
        goto(12); chk("p_c12", {28'd0, phase_a}, 32'd1);
        goto(13); chk("p_c13", {28'd0, phase_a}, 32'd2);

        // Write raised in S_P1: commit in first IDLE (16), pulse at 17 only
        do_write(13, 5'h04, 8'h41, ackc);
        chk("t3_ack_cycle", 32'(ackc), 32'd17);
        chk("t3_single", {31'd0, reg_we_a}, 32'd0);
        goto(24); chk("p_c24", {28'd0, phase_a}, 32'd1);

        // Write raised in the tick cycle: sequence first, commit at 40
        do_write(35, 5'h1f, 8'ha5, ackc);
        chk("t4_ack_cycle", 32'(ackc), 32'd41);

        // Back-to-back writes with wr_req held across the ack
        do_write(53, 5'h0a, 8'h3c, ackc);
        chk("b2b_first", 32'(ackc), 32'd54);
        do_write(55, 5'h00, 8'hff, ackc);
        chk("b2b_second", 32'(ackc), 32'd56);
        do_write(59, 5'h11, 8'h00, ackc);
        chk("tick_write", 32'(ackc), 32'd65);

        // Reset in S_P12 aborts the sequence and restarts the divider
        goto(74);
        chk("p_c74", {28'd0, phase_a}, 32'd4);
        res_a = 1'b1;
        step();
        res_a = 1'b0;
        chk("mid_rst_phase", {28'd0, phase_a}, 32'd0);
`ifdef SID_CYCLE_COUNT_EN
        chk("mid_rst_cnt", cnt_a, 32'd0);
`endif
        goto(11); chk("r_c11", {28'd0, phase_a}, 32'd0);
        goto(12); chk("r_c12", {28'd0, phase_a}, 32'd1);
`ifdef SID_CYCLE_COUNT_EN
        chk("cnt_after_one", cnt_a, 32'd1);
`endif
        goto(40);
        chk("a_no_overrun", {31'd0, ovr_a}, 32'd0);

        // Illegal ratio INC=1, MOD=3: tick at 2 starts a sequence, tick at 5 is dropped
        res_b = 1'b0;
        repeat (3) step();
        chk("b_p21", {28'd0, phase_b}, 32'd1);
        repeat (2) step();
        chk("b_ovr_c5", {31'd0, ovr_b}, 32'd0);
        step();
        chk("b_ovr_c6", {31'd0, ovr_b}, 32'd1);
        repeat (20) step();
        chk("b_ovr_sticky", {31'd0, ovr_b}, 32'd1);
        res_b = 1'b1;
        step();
        chk("b_ovr_cleared", {31'd0, ovr_b}, 32'd0);
        chk("b_phase_cleared", {28'd0, phase_b}, 32'd0);

        // Real ratio: strobes in cycles 1..19999 = floor(19999*985248/12000000) = 1641
        res_c = 1'b0;
        strobes = 0;
        for (int k = 0; k < 20000; k++) begin
            if (phase_c[0] === 1'b1) strobes++;
            if (k < 19999) step();
        end
        chk("c_strobes", 32'(strobes), 32'd1641);
        chk("c_no_overrun", {31'd0, ovr_c}, 32'd0);
`ifdef SID_CYCLE_COUNT_EN
        chk("c_cycle_cnt", cnt_c, 32'd1641);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
